// File: rtl/uart_pattern_rx.sv
// UART receiver (oversampled, mid-bit sampling, optional parity) with serial bit-pattern detector.
// Latency: rx_valid one cycle after the mid-stop-bit sample; match_pulse one cycle after a data-bit sample.
// No backpressure: results are single-cycle pulses, rx_data holds until the next frame completes.
module uart_pattern_rx #(
  parameter int CLK_FREQ   = 25_000_000,
  parameter int BAUD_RATE  = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int PAT_WIDTH  = 4,
  parameter logic [PAT_WIDTH-1:0] PATTERN = PAT_WIDTH'(4'b1011)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_serial_in,
  input  logic                 pattern_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 match_pulse,
  output logic [15:0]          match_count
);

  localparam int DIV    = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W   = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int FILL_W = $clog2(PAT_WIDTH + 1);

  generate
    if (DIV < 2 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || PAT_WIDTH < 1 || PAT_WIDTH > 32) begin : g_bad_params
      $error("uart_pattern_rx: illegal parameter combination");
    end
  endgenerate

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t               r_state;
  logic                 r_sync1, r_rx_s, r_rx_prev;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [OS_W-1:0]      r_os_cnt;
  logic [BIT_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic [PAT_WIDTH-1:0] r_hist;
  logic [FILL_W-1:0]    r_hist_fill;
  logic                 r_par_err;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_valid, r_parity_err, r_frame_err, r_match_pulse;
  logic [15:0]          r_match_count;

  logic                 w_start_edge, w_os_tick, w_mid_start, w_mid_bit, w_match;
  logic [PAT_WIDTH:0]   w_hist_ext;
  logic [PAT_WIDTH-1:0] w_hist_next;
  logic [FILL_W-1:0]    w_fill_next;

  // Falling edge only counts while idle, so a line held low never retriggers.
  assign w_start_edge = (r_state == S_IDLE) && r_rx_prev && !r_rx_s;
  assign w_os_tick    = (r_div_cnt == DIV_W'(DIV - 1));
  assign w_mid_start  = w_os_tick && (r_os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign w_mid_bit    = w_os_tick && (r_os_cnt == OS_W'(OVERSAMPLE - 1));

  // History after shifting in the current line bit; the extra bit keeps PAT_WIDTH=1 legal.
  assign w_hist_ext   = {r_hist, r_rx_s};
  assign w_hist_next  = w_hist_ext[PAT_WIDTH-1:0];
  assign w_fill_next  = (r_hist_fill == FILL_W'(PAT_WIDTH)) ? r_hist_fill : r_hist_fill + 1'b1;
  assign w_match      = pattern_en && (w_fill_next == FILL_W'(PAT_WIDTH)) && (w_hist_next == PATTERN);

  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign parity_err   = r_parity_err;
  assign frame_err    = r_frame_err;
  assign match_pulse  = r_match_pulse;
  assign match_count  = r_match_count;

  // Two-flop synchronizer plus one delayed copy for edge detection; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_serial_in;
      r_rx_s    <= r_sync1;
      r_rx_prev <= r_rx_s;
    end
  end

  // Free-running oversample tick divider, re-phased to the detected start edge.
  always_ff @(posedge clk) begin
    if (reset || w_start_edge || w_os_tick) r_div_cnt <= '0;
    else                                    r_div_cnt <= r_div_cnt + 1'b1;
  end

  // Receive FSM: mid-bit sampling, data/history shifting, parity/stop checks, registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_os_cnt      <= '0;
      r_bit_idx     <= '0;
      r_shift       <= '0;
      r_hist        <= '0;
      r_hist_fill   <= '0;
      r_par_err     <= 1'b0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_parity_err  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_match_pulse <= 1'b0;
      r_match_count <= '0;
    end else begin
      r_rx_valid    <= 1'b0;
      r_match_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_os_cnt <= '0;
          if (w_start_edge) r_state <= S_START;
        end
        S_START: begin
          if (w_mid_start) begin
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
            // A high line at mid start bit is a glitch: drop back silently.
            r_state   <= r_rx_s ? S_IDLE : S_DATA;
          end else if (w_os_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_mid_bit) begin
            r_os_cnt    <= '0;
            r_shift     <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            r_hist      <= w_hist_next;
            r_hist_fill <= w_fill_next;
            if (w_match) begin
              r_match_pulse <= 1'b1;
              if (r_match_count != 16'hFFFF) r_match_count <= r_match_count + 16'd1;
            end
            if (r_bit_idx == BIT_W'(DATA_BITS - 1)) r_state <= (PARITY != 0) ? S_PAR : S_STOP;
            else                                    r_bit_idx <= r_bit_idx + 1'b1;
          end else if (w_os_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        S_PAR: begin
          if (w_mid_bit) begin
            r_os_cnt  <= '0;
            r_par_err <= ((^r_shift) ^ r_rx_s) != (PARITY == 2);
            r_state   <= S_STOP;
          end else if (w_os_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_mid_bit) begin
            r_os_cnt     <= '0;
            r_rx_valid   <= 1'b1;
            r_rx_data    <= r_shift;
            r_parity_err <= r_par_err;
            r_frame_err  <= !r_rx_s;
            // A framing error means bit alignment is suspect, so restart pattern history.
            if (!r_rx_s) begin
              r_hist      <= '0;
              r_hist_fill <= '0;
            end
            r_state <= S_IDLE;
          end else if (w_os_tick) begin
            r_os_cnt <= r_os_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pattern_rx.sv
// Directed bench: instance A is 8N1 with pattern 1011, instance B is 8E1.
// Clock/baud chosen so DIV=2 and one bit lasts 32 clocks.
module tb_uart_pattern_rx;

  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic rx_a, rx_b, pen_a;

  logic [7:0]  data_a, data_b;
  logic        valid_a, valid_b, pe_a, pe_b, fe_a, fe_b, match_a, match_b;
  logic [15:0] mc_a, mc_b;

  int checks = 0;
  int errors = 0;
  int va = 0;
  int ma = 0;
  int vb = 0;

  uart_pattern_rx #(
    .CLK_FREQ(3_686_400), .BAUD_RATE(115_200), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .PAT_WIDTH(4), .PATTERN(4'b1011)
  ) u_a (
    .clk(clk), .reset(reset), .rx_serial_in(rx_a), .pattern_en(pen_a),
    .rx_data(data_a), .rx_valid(valid_a), .parity_err(pe_a), .frame_err(fe_a),
    .match_pulse(match_a), .match_count(mc_a)
  );

  uart_pattern_rx #(
    .CLK_FREQ(3_686_400), .BAUD_RATE(115_200), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(1), .PAT_WIDTH(4), .PATTERN(4'b1011)
  ) u_b (
    .clk(clk), .reset(reset), .rx_serial_in(rx_b), .pattern_en(1'b1),
    .rx_data(data_b), .rx_valid(valid_b), .parity_err(pe_b), .frame_err(fe_b),
    .match_pulse(match_b), .match_count(mc_b)
  );

  // Pulse counters observed on the active edge.
  always @(posedge clk) begin
    if (valid_a) va <= va + 1;
    if (match_a) ma <= ma + 1;
    if (valid_b) vb <= vb + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b, input bit lane);
    if (lane) rx_b = b;
    else      rx_a = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input bit lane,
                            input bit with_par, input logic par);
    send_bit(1'b0, lane);
    for (int i = 0; i < 8; i++) send_bit(d[i], lane);
    if (with_par) send_bit(par, lane);
    send_bit(stop, lane);
    if (!stop) send_bit(1'b1, lane);
  endtask

  // 8N1 frame on lane A, checking the match pulse count after each of the first four data bits.
  task automatic send_steps(input logic [7:0] d, input int exp_before, input int exp_after,
                            input string tag);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      send_bit(d[i], 1'b0);
      check({tag, "_early"}, ma, exp_before);
    end
    send_bit(d[3], 1'b0);
    check({tag, "_bit4"}, ma, exp_after);
    for (int i = 4; i < 8; i++) send_bit(d[i], 1'b0);
    send_bit(1'b1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    pen_a = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_mcount", mc_a, 0);
    reset = 1'b0;

    // Idle line for 20 bit-times.
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("idle_vcnt", va, 0);
    check("idle_mcnt", ma, 0);
    check("idle_fe", fe_a, 0);
    check("idle_pe", pe_a, 0);
    check("idle_mcount", mc_a, 0);

    // 0x0D: line bits 1,0,1,1 -> match right after the 4th data bit.
    send_steps(8'h0D, 0, 1, "m1");
    check("m1_vcnt", va, 1);
    check("m1_data", data_a, 8'h0D);
    check("m1_mcount", mc_a, 1);

    // Same frame with detection disabled.
    pen_a = 1'b0;
    send_steps(8'h0D, 1, 1, "mdis");
    pen_a = 1'b1;
    check("mdis_vcnt", va, 2);
    check("mdis_mcount", mc_a, 1);

    // 0xA5 clean frame, history never reaches 1011.
    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("a5_vcnt", va, 3);
    check("a5_data", data_a, 8'hA5);
    check("a5_pe", pe_a, 0);
    check("a5_fe", fe_a, 0);
    check("a5_mcnt", ma, 1);

    // Short low glitch (4 ticks = 8 clocks) must not produce a frame.
    rx_a = 1'b0;
    repeat (8) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_vcnt", va, 3);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    check("3c_vcnt", va, 4);
    check("3c_data", data_a, 8'h3C);

    // 0xFF with stop bit 0 -> framing error, history cleared.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fe_vcnt", va, 5);
    check("fe_flag", fe_a, 1);
    check("fe_data", data_a, 8'hFF);
    check("fe_mcnt", ma, 1);

    // After the error, the match needs four fresh bits.
    send_steps(8'h0D, 1, 2, "mfe");
    check("mfe_fe", fe_a, 0);
    check("mfe_vcnt", va, 6);
    check("mfe_mcount", mc_a, 2);

    // Old history 1111 plus new 0,1,1 would form 1011 if not cleared.
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h06, 1'b1, 1'b0, 1'b0, 1'b0);
    check("hclr_mcnt", ma, 2);
    check("hclr_data", data_a, 8'h06);
    check("hclr_vcnt", va, 8);

    // Even parity: 0x01 with parity bit 0 is wrong, 0x03 with parity bit 0 is right.
    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par1_vcnt", vb, 1);
    check("par1_data", data_b, 8'h01);
    check("par1_pe", pe_b, 1);
    check("par1_fe", fe_b, 0);
    send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0);
    check("par2_vcnt", vb, 2);
    check("par2_pe", pe_b, 0);

    // Reset in the middle of the data bits abandons the frame.
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_data", data_b, 0);
    check("mrst_pe", pe_b, 0);
    check("mrst_valid", valid_b, 0);
    check("mrst_mcount_a", mc_a, 0);
    reset = 1'b0;
    rx_b  = 1'b1;
    repeat (12 * BIT_CLKS) @(negedge clk);
    check("mrst_vcnt", vb, 2);
    check("mrst_data_hold", data_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
